rr_arb4: RTL and testbench

Four-channel round-robin arbiter and output register feeding the 4:1 data-select mux stage. Each channel presents data with a valid/ready handshake. The block picks one requesting channel per cycle under fair rotating priority and drives the mux select code. It instantiates the mux for the data path and registers the selected word with its channel index for a single valid/ready consumer.

---
 rtl/arb_pkg.sv | 6 +
 rtl/rr_arb4_if.sv | 29 ++
 rtl/mux4.sv | 11 +
 rtl/rr_arb4_pick4.sv | 21 ++
 rtl/rr_arb4.sv | 58 +++++
 tb/tb_rr_arb4.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared select type and sizing constants for the round-robin arbiter
package arb_pkg;
    typedef logic [1:0] sel_t;
    localparam int NUM_CH = 4;
    localparam int STAT_W = 16;
endpackage

// File: rtl/rr_arb4_if.sv
// rr_arb4_if: channel and consumer handshake bundle; stat_clr/cnt0..cnt3 exist only with ARB_STATS_EN
interface rr_arb4_if #(parameter int W = 32);
    import arb_pkg::*;
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_ready;
    logic [W-1:0]      d0, d1, d2, d3;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    sel_t              out_sel;
`ifdef ARB_STATS_EN
    logic              stat_clr;
    logic [STAT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif
    modport slave (
        input  in_valid, d0, d1, d2, d3, out_ready,
        output in_ready, out_valid, out_data, out_sel
`ifdef ARB_STATS_EN
        , input stat_clr, output cnt0, cnt1, cnt2, cnt3
`endif
    );
    modport master (
        output in_valid, d0, d1, d2, d3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
`ifdef ARB_STATS_EN
        , output stat_clr, input cnt0, cnt1, cnt2, cnt3
`endif
    );
endinterface

// File: rtl/mux4.sv
// mux4: 4:1 data-select mux stage
module mux4 #(parameter int w = 32) (
    input  logic [1:0]   i_sel,
    input  logic [w-1:0] i_d0,
    input  logic [w-1:0] i_d1,
    input  logic [w-1:0] i_d2,
    input  logic [w-1:0] i_d3,
    output logic [w-1:0] o_y
);
    assign o_y = i_sel[1] ? (i_sel[0] ? i_d3 : i_d2) : (i_sel[0] ? i_d1 : i_d0);
endmodule

// File: rtl/rr_arb4_pick4.sv
// rr_pick4: rotating-priority encoder, searches ptr+1, ptr+2, ptr+3, ptr
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] i_valid,
    input  sel_t              i_ptr,
    output logic              o_any,
    output sel_t              o_g
);
    sel_t w_c;
    assign o_any = |i_valid;
    // walk from lowest priority to highest so the nearest requester after ptr wins
    always_comb begin
        o_g = i_ptr;
        w_c = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_c = i_ptr + sel_t'(k + 1);
            if (i_valid[w_c]) o_g = w_c;
        end
    end
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: 4-channel round-robin arbiter with registered output; ARB_STATS_EN adds grant counters
module rr_arb4
    import arb_pkg::*;
#(parameter int W = 32) (
    input logic        clk,
    input logic        rst_n,
    rr_arb4_if.slave   bus
);
    sel_t         r_ptr, r_sel, w_g;
    logic         r_valid, w_any, w_free, w_xfer;
    logic [W-1:0] r_data, w_mux;

    rr_pick4 u_pick (.i_valid(bus.in_valid), .i_ptr(r_ptr), .o_any(w_any), .o_g(w_g));

    mux4 #(.w(W)) u_mux (
        .i_sel(w_g), .i_d0(bus.d0), .i_d1(bus.d1), .i_d2(bus.d2), .i_d3(bus.d3), .o_y(w_mux)
    );

    assign w_free        = !r_valid || bus.out_ready;
    assign w_xfer        = rst_n && w_any && w_free;
    assign bus.in_ready  = w_xfer ? 4'b0001 << w_g : 4'b0000;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;

    // output register: load on transfer (replacing any drained word), clear valid on drain only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= 2'd3;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_mux;
            r_sel   <= w_g;
            r_ptr   <= w_g;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] r_cnt [NUM_CH];
    // per-channel grant counters; clear takes priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || bus.stat_clr) begin
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else if (w_xfer) begin
            r_cnt[w_g] <= r_cnt[w_g] + 1'b1;
        end
    end
    assign bus.cnt0 = r_cnt[0];
    assign bus.cnt1 = r_cnt[1];
    assign bus.cnt2 = r_cnt[2];
    assign bus.cnt3 = r_cnt[3];
`endif
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: scoreboard bench for rr_arb4 (W=8); counter checks run when ARB_STATS_EN is defined
module tb_rr_arb4;
    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    exp_t       q[$];
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] dv [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

    rr_arb4_if #(.W(8)) bus ();
    rr_arb4 #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        q.push_back('{sel: 2'(s), data: dv[s]});
    endtask

    // monitor: every cycle the consumer takes a word, compare it to the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL mon_unexpected: got sel %0d data %h expected no word", bus.out_sel, bus.out_data);
                end else begin
                    e = q.pop_front();
                    chk("mon_sel", 32'(bus.out_sel), 32'(e.sel));
                    chk("mon_data", 32'(bus.out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 4'hF;
        bus.out_ready = 1'b0;
        bus.d0 = dv[0];
        bus.d1 = dv[1];
        bus.d2 = dv[2];
        bus.d3 = dv[3];
`ifdef ARB_STATS_EN
        bus.stat_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_sel", 32'(bus.out_sel), 0);
        chk("rst_data", 32'(bus.out_data), 0);

        // all channels requesting: grants rotate 0,1,2,3,0
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2 chk("rot_ready", 32'(bus.in_ready), 32'(1) << (i % 4));
            push(i % 4);
            tick();
            chk("rot_valid", 32'(bus.out_valid), 1);
        end
        bus.in_valid = 4'b0000;
        tick();
        chk("rot_drain", 32'(bus.out_valid), 0);

        // single shot on channel 2, then drain one cycle after out_ready
        bus.in_valid = 4'b0100;
        #2 chk("shot_ready", 32'(bus.in_ready), 32'h4);
        push(2);
        tick();
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b0;
        chk("shot_valid", 32'(bus.out_valid), 1);
        chk("shot_sel", 32'(bus.out_sel), 2);
        chk("shot_data", 32'(bus.out_data), 32'hA2);
        #2 chk("shot_ready_off", 32'(bus.in_ready), 0);
        tick();
        chk("shot_hold", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        tick();
        chk("shot_drop", 32'(bus.out_valid), 0);

        // stall: ptr=2, channels 0 and 1 requesting, consumer blocked
        bus.in_valid = 4'b0011;
        bus.out_ready = 1'b0;
        #2 chk("stall_first_ready", 32'(bus.in_ready), 32'h1);
        push(0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2 chk("stall_ready", 32'(bus.in_ready), 0);
            chk("stall_sel", 32'(bus.out_sel), 0);
            chk("stall_data", 32'(bus.out_data), 32'hA0);
            tick();
        end
        bus.out_ready = 1'b1;
        #2 chk("release_ready1", 32'(bus.in_ready), 32'h2);
        push(1);
        tick();
        #2 chk("release_ready0", 32'(bus.in_ready), 32'h1);
        push(0);
        tick();
        bus.in_valid = 4'b0000;
        tick();
        chk("release_drain", 32'(bus.out_valid), 0);

        // wrap: grant 3, then 0 and 3 requesting -> 0 first
        bus.in_valid = 4'b1000;
        #2 chk("wrap_ready3", 32'(bus.in_ready), 32'h8);
        push(3);
        tick();
        bus.in_valid = 4'b1001;
        #2 chk("wrap_ready0", 32'(bus.in_ready), 32'h1);
        push(0);
        tick();
        #2 chk("wrap_ready3b", 32'(bus.in_ready), 32'h8);
        push(3);
        tick();
        bus.in_valid = 4'b0000;
        tick();

        // reset while a word is held under stall
        bus.in_valid = 4'b0010;
        bus.out_ready = 1'b0;
        push(1);
        tick();
        bus.in_valid = 4'b0000;
        chk("midrst_held", 32'(bus.out_valid), 1);
        tick();
        rst_n = 1'b0;
        #2 chk("midrst_ready", 32'(bus.in_ready), 0);
        tick();
        q.delete();
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_sel", 32'(bus.out_sel), 0);
        chk("midrst_data", 32'(bus.out_data), 0);
        rst_n = 1'b1;
        bus.in_valid = 4'hF;
        bus.out_ready = 1'b1;
        #2 chk("midrst_first", 32'(bus.in_ready), 32'h1);
        push(0);
        tick();
        bus.in_valid = 4'b0000;
        tick();

`ifdef ARB_STATS_EN
        bus.in_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            push(1);
            tick();
        end
        chk("cnt1_five", 32'(bus.cnt1), 5);
        bus.stat_clr = 1'b1;
        push(1);
        tick();
        bus.stat_clr = 1'b0;
        chk("cnt1_clr", 32'(bus.cnt1), 0);
        bus.in_valid = 4'b0000;
        tick();
        bus.in_valid = 4'b0100;
        for (int i = 0; i < 65536; i++) begin
            push(2);
            tick();
            if (i == 65534) chk("cnt2_max", 32'(bus.cnt2), 32'hFFFF);
        end
        bus.in_valid = 4'b0000;
        tick();
        chk("cnt2_wrap", 32'(bus.cnt2), 0);
        chk("cnt0_one", 32'(bus.cnt0), 1);
        chk("cnt1_zero", 32'(bus.cnt1), 0);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
